sprite_rom_arbiter: RTL and testbench

- Shares one synchronous sprite ROM read port between NUM_REQ sprite draw units (Link, sword, enemy, NPC).
- The ROM has a 1024-word, 1-cycle registered read port: address applied, q valid next cycle.
- Round-robin arbitration issues one ROM read per clock, fully pipelined, and returns tagged read data to the winning requester.
- Sits between the per-sprite address generators and a shared sprite ROM instance, upstream of the colour mapper.

---
 rtl/sprite_rom_arbiter.sv | 104 ++++++++++
 tb/tb_sprite_rom_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
//   Shares one sprite ROM read port (1-cycle registered q) among NUM_REQ
//   sprite draw units. A round-robin pick issues at most one ROM read per
//   clock. Read data comes back two cycles after the request was sampled,
//   tagged with the id of the requester that won it.
//
// Ports
//   clock, reset_n  : clock, synchronous active-low reset
//   en              : arbitration enable (low during blanking blocks grants)
//   req, req_addr   : per-requester level request and packed read address
//   gnt             : registered one-hot grant pulse
//   rom_address     : registered address to the shared ROM
//   rom_q           : ROM read data
//   rsp_valid/id    : response qualifier and owner tag
//   rsp_data        : rom_q passthrough; qualify it with rsp_valid
//   busy            : a granted read is still in flight
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 4,
  parameter int ID_W    = 2
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      en,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_address,
  input  logic [DATA_W-1:0]         rom_q,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy
);

  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ID_W-1:0]    last_q, last_d;
  // Stage 1 = address issued to ROM, stage 2 = ROM q on the bus.
  logic [2:1]           vld_pipe_q;
  logic [2:1][ID_W-1:0] id_pipe_q;
  logic [ID_W-1:0]      id1_d;

  logic            win_vld;
  logic [ID_W-1:0] win_id;
  logic            grant;

  // Round-robin search starting just after the last winner. The modulo
  // keeps every probed index inside 0..NUM_REQ-1 for any NUM_REQ.
  always_comb begin
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win_id  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win_id  = ID_W'(idx);
      end
    end
  end

  assign grant = en & win_vld;

  always_comb begin
    gnt_d  = '0;
    addr_d = addr_q;
    last_d = last_q;
    id1_d  = id_pipe_q[1];
    if (grant) begin
      gnt_d  = NUM_REQ'(1) << win_id;
      addr_d = req_addr[int'(win_id)*ADDR_W +: ADDR_W];
      last_d = win_id;
      id1_d  = win_id;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      gnt_q      <= '0;
      addr_q     <= '0;
      last_q     <= ID_W'(NUM_REQ - 1);
      vld_pipe_q <= '0;
      id_pipe_q  <= '0;
    end else begin
      gnt_q        <= gnt_d;
      addr_q       <= addr_d;
      last_q       <= last_d;
      vld_pipe_q   <= {vld_pipe_q[1], grant};
      id_pipe_q[1] <= id1_d;
      id_pipe_q[2] <= id_pipe_q[1];
    end
  end

  assign gnt         = gnt_q;
  assign rom_address = addr_q;
  assign rsp_valid   = vld_pipe_q[2];
  assign rsp_id      = id_pipe_q[2];
  assign rsp_data    = rom_q;
  assign busy        = |vld_pipe_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: directed vectors, a cycle-history model of
// the expected grant/response stream, and literal spot checks.
module tb_sprite_rom_arbiter;
  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 4;
  localparam int IW = 2;
  localparam int HMAX = 4096;

  logic            clock = 1'b0;
  logic            reset_n, en;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    gnt;
  logic [AW-1:0]   rom_address;
  logic [DW-1:0]   rom_q;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic [DW-1:0]   rsp_data;
  logic            busy;

  sprite_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .clock(clock), .reset_n(reset_n), .en(en), .req(req), .req_addr(req_addr),
    .gnt(gnt), .rom_address(rom_address), .rom_q(rom_q), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clock = ~clock;

  // Shared ROM: registered read.
  logic [DW-1:0] mem [0:1023];
  always @(posedge clock) rom_q <= mem[rom_address];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: for every clock edge, which requester (or -1) got a read and
  // what address the ROM port holds afterwards. Outputs in a cycle follow
  // from the edge just before it (grant) and the one before that (data).
  int            win_a  [0:HMAX-1];
  int            addr_a [0:HMAX-1];
  int            cyc = 0;
  int            m_last = N - 1;
  int            m_addr = 0;

  always @(posedge clock) begin
    int w;
    int idx;
    w = -1;
    cyc++;
    if (!reset_n) begin
      m_last = N - 1;
      m_addr = 0;
      win_a[cyc-1] = -1;   // anything in flight is dropped
    end else if (en && req != 0) begin
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (w < 0 && req[idx]) w = idx;
      end
      m_last = w;
      m_addr = int'(req_addr[w*AW +: AW]);
    end
    win_a[cyc]  = w;
    addr_a[cyc] = m_addr;
  end

  always @(negedge clock) begin
    int eg;
    int prev;
    if (cyc >= 1) begin
      eg   = (win_a[cyc] >= 0) ? (1 << win_a[cyc]) : 0;
      prev = win_a[cyc-1];
      chk("model.gnt", int'(gnt), eg);
      chk("model.rom_address", int'(rom_address), addr_a[cyc]);
      chk("model.rsp_valid", int'(rsp_valid), int'(prev >= 0));
      if (prev >= 0) begin
        chk("model.rsp_id", int'(rsp_id), prev);
        chk("model.rsp_data", int'(rsp_data), int'(mem[addr_a[cyc-1]]));
      end
      chk("model.busy", int'(busy), int'(win_a[cyc] >= 0 || prev >= 0));
    end
  end

  task automatic step();
    @(negedge clock);
  endtask

  task automatic set_addr(input int i, input int a);
    req_addr[i*AW +: AW] = AW'(a);
  endtask

  localparam int NMIX = 8;
  logic [N-1:0] mix_req [NMIX] = '{4'b0101, 4'b0110, 4'b1111, 4'b0001,
                                   4'b1000, 4'b0000, 4'b1011, 4'b1111};
  logic         mix_en  [NMIX] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    for (int i = 0; i < HMAX; i++) begin win_a[i] = -1; addr_a[i] = 0; end
    for (int a = 0; a < 1024; a++) mem[a] = DW'((a * 7 + (a >> 3)) & 15);
    mem[10'h155] = 4'hA;

    reset_n  = 1'b0;
    en       = 1'b1;
    req      = 4'b1111;
    req_addr = '0;
    repeat (3) step();
    chk("reset.gnt", int'(gnt), 0);
    chk("reset.rsp_valid", int'(rsp_valid), 0);
    chk("reset.rom_address", int'(rom_address), 0);
    chk("reset.rsp_id", int'(rsp_id), 0);
    reset_n = 1'b1;
    step();
    chk("reset.first_gnt", int'(gnt), 4'b0001);
    req = '0;
    repeat (3) step();

    // Single read from requester 2.
    set_addr(2, 10'h155);
    req = 4'b0100;
    step();
    chk("single.gnt", int'(gnt), 4'b0100);
    chk("single.rom_address", int'(rom_address), 10'h155);
    req = '0;
    step();
    chk("single.rsp_valid", int'(rsp_valid), 1);
    chk("single.rsp_id", int'(rsp_id), 2);
    chk("single.rsp_data", int'(rsp_data), 4'hA);
    repeat (2) step();

    // Round-robin with all four requesting; first park the pointer at 3.
    for (int i = 0; i < N; i++) set_addr(i, 16 * (i + 1) + 5);
    req = 4'b1000;
    step();
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr.gnt", int'(gnt), 1 << (i % N));
    end

    // Partial set with wrap from pointer 3.
    req = 4'b1010;
    step(); chk("wrap.gnt0", int'(gnt), 4'b0010);
    step(); chk("wrap.gnt1", int'(gnt), 4'b1000);
    step(); chk("wrap.gnt2", int'(gnt), 4'b0010);
    req = '0;
    repeat (3) step();

    // en gating while requesters 0 and 1 stream.
    req = 4'b0011;
    repeat (3) step();
    en = 1'b0;
    step();
    chk("en.gnt_off", int'(gnt), 0);
    chk("en.rsp_valid_tail", int'(rsp_valid), 1);
    repeat (3) step();
    chk("en.idle_busy", int'(busy), 0);
    en = 1'b1;
    step();
    chk("en.resume_gnt", int'(gnt), 4'b0010);
    req = '0;
    repeat (3) step();

    // Reset one cycle after a grant: the pending read must vanish.
    set_addr(0, 10'h3C3);
    req = 4'b0001;
    step();
    reset_n = 1'b0;
    req     = '0;
    step();
    chk("midreset.rsp_valid", int'(rsp_valid), 0);
    chk("midreset.busy", int'(busy), 0);
    reset_n = 1'b1;
    step();
    chk("midreset.rsp_valid2", int'(rsp_valid), 0);

    // Mixed patterns, checked by the model only.
    for (int i = 0; i < N; i++) set_addr(i, 200 + 37 * i);
    for (int i = 0; i < NMIX; i++) begin
      req = mix_req[i];
      en  = mix_en[i];
      step();
      set_addr(i % N, 300 + 11 * i);
    end
    req = '0;
    en  = 1'b1;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
